// File: rtl/oled_pkg.sv
// Shared constants and types for the SSD1306 frame sequencer and its init ROM.
package oled_pkg;

    localparam int unsigned MST_W      = 4;
    localparam int unsigned CMD_QW     = 5;
    localparam int unsigned DATA_QW    = 8;
    localparam int unsigned CMD_IDX_W  = 5;
    localparam int unsigned FB_AW      = 10;
    localparam int unsigned DLY_W      = 17;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned ADDR_W     = 7;

    localparam int unsigned OLED_WIDTH    = 128;
    localparam int unsigned OLED_HEIGHT   = 64;
    localparam int unsigned OLED_FB_BYTES = OLED_WIDTH * OLED_HEIGHT / 8;
    localparam int unsigned OLED_INIT_LEN = 31;

    localparam logic [BYTE_W-1:0] CTRL_CMD  = 8'h80;
    localparam logic [BYTE_W-1:0] CTRL_DATA = 8'hC0;
    localparam logic [BYTE_W-1:0] ROM_NOP   = 8'hE3;

    // Encodings of the downstream I2C master's FSM
    typedef enum logic [MST_W-1:0] {
        M_IDLE          = 4'd0,
        M_START         = 4'd1,
        M_WRITE_CONTROL = 4'd3,
        M_WRITE_COMMAND = 4'd4,
        M_WRITE_DATA    = 4'd5,
        M_ACK           = 4'd7,
        M_STOP          = 4'd8
    } mst_state_e;

    typedef enum logic [2:0] {
        SEQ_PWR_WAIT,
        SEQ_REQ,
        SEQ_INIT,
        SEQ_DATA,
        SEQ_FAULT
    } seq_state_e;

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 power-up command list; indices past the list return a NOP command.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [CMD_IDX_W-1:0] idx,
    output logic [BYTE_W-1:0]    cmd_c
);

    always_comb begin
        cmd_c = ROM_NOP;
        case (idx)
            5'd0:    cmd_c = 8'hAE;
            5'd1:    cmd_c = 8'hD5;
            5'd2:    cmd_c = 8'h80;
            5'd3:    cmd_c = 8'hA8;
            5'd4:    cmd_c = 8'h3F;
            5'd5:    cmd_c = 8'hD3;
            5'd6:    cmd_c = 8'h00;
            5'd7:    cmd_c = 8'h40;
            5'd8:    cmd_c = 8'h8D;
            5'd9:    cmd_c = 8'h14;
            5'd10:   cmd_c = 8'h20;
            5'd11:   cmd_c = 8'h00;
            5'd12:   cmd_c = 8'hA1;
            5'd13:   cmd_c = 8'hC8;
            5'd14:   cmd_c = 8'hDA;
            5'd15:   cmd_c = 8'h12;
            5'd16:   cmd_c = 8'h81;
            5'd17:   cmd_c = 8'hCF;
            5'd18:   cmd_c = 8'hD9;
            5'd19:   cmd_c = 8'hF1;
            5'd20:   cmd_c = 8'hDB;
            5'd21:   cmd_c = 8'h40;
            5'd22:   cmd_c = 8'hA4;
            5'd23:   cmd_c = 8'hA6;
            5'd24:   cmd_c = 8'h21;
            5'd25:   cmd_c = 8'h00;
            5'd26:   cmd_c = 8'h7F;
            5'd27:   cmd_c = 8'h22;
            5'd28:   cmd_c = 8'h00;
            5'd29:   cmd_c = 8'h07;
            5'd30:   cmd_c = 8'hAF;
            default: cmd_c = ROM_NOP;
        endcase
    end

endmodule

// File: rtl/oled_frame_sequencer.sv
// Byte source for the SSD1306 I2C master: power-up wait, init command list,
// then a continuously wrapping framebuffer stream, paced by the master's pointers.
module oled_frame_sequencer
    import oled_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h3C,
    parameter int unsigned       PWR_DELAY   = 100000,
    parameter int unsigned       RETRY_DELAY = 50000,
    parameter int unsigned       FB_BYTES    = OLED_FB_BYTES,
    parameter int unsigned       INIT_LEN    = OLED_INIT_LEN
) (
    input  logic                 CLK,
    input  logic                 NRST,
    input  logic [MST_W-1:0]     m_state,
    input  logic [CMD_QW-1:0]    m_command_queue,
    input  logic [DATA_QW-1:0]   m_data_queue,
    output logic                 start_n,
    output logic [ADDR_W-1:0]    slave_addr,
    output logic                 read_write,
    output logic [BYTE_W-1:0]    control_frame,
    output logic [BYTE_W-1:0]    cmd_byte,
    output logic [BYTE_W-1:0]    data_byte,
    output logic [FB_AW-1:0]     fb_addr,
    input  logic [BYTE_W-1:0]    fb_data,
    output logic                 init_done,
    output logic                 frame_done,
    output logic                 fault
);

    localparam logic [DLY_W-1:0]     PWR_LAST   = DLY_W'(PWR_DELAY - 1);
    localparam logic [DLY_W-1:0]     RETRY_LAST = DLY_W'(RETRY_DELAY - 1);
    localparam logic [FB_AW-1:0]     FB_LAST    = FB_AW'(FB_BYTES - 1);
    localparam logic [CMD_IDX_W-1:0] INIT_LAST  = CMD_IDX_W'(INIT_LEN - 1);

    seq_state_e             state, state_nxt;
    logic [DLY_W-1:0]       dly_cnt, dly_cnt_nxt;
    logic [CMD_IDX_W-1:0]   cmd_idx, cmd_idx_nxt;
    logic [FB_AW-1:0]       fb_addr_nxt;
    logic                   init_done_nxt, frame_done_nxt, fault_nxt, start_n_nxt;
    logic [BYTE_W-1:0]      control_frame_nxt;
    logic [CMD_QW-1:0]      prev_cmd_q;
    logic [DATA_QW-1:0]     prev_data_q;
    logic                   idle_d;
    logic                   cmd_adv, data_adv, mst_idle, mst_hung;

    assign slave_addr = SLAVE_ADDR;
    assign read_write = 1'b0;
    assign data_byte  = fb_data;

    oled_init_rom u_rom (
        .idx   (cmd_idx),
        .cmd_c (cmd_byte)
    );

    // Any pointer change is one consumed byte, including the counter wrap
    assign cmd_adv  = (m_command_queue != prev_cmd_q);
    assign data_adv = (m_data_queue != prev_data_q);
    assign mst_idle = (m_state == M_IDLE);
    // Master sitting in IDLE for two cycles means it abandoned the transfer
    assign mst_hung = mst_idle && idle_d;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state         <= SEQ_PWR_WAIT;
            dly_cnt       <= '0;
            cmd_idx       <= '0;
            fb_addr       <= '0;
            init_done     <= 1'b0;
            frame_done    <= 1'b0;
            fault         <= 1'b0;
            start_n       <= 1'b1;
            control_frame <= CTRL_CMD;
            idle_d        <= 1'b0;
        end else begin
            state         <= state_nxt;
            dly_cnt       <= dly_cnt_nxt;
            cmd_idx       <= cmd_idx_nxt;
            fb_addr       <= fb_addr_nxt;
            init_done     <= init_done_nxt;
            frame_done    <= frame_done_nxt;
            fault         <= fault_nxt;
            start_n       <= start_n_nxt;
            control_frame <= control_frame_nxt;
            idle_d        <= mst_idle;
        end
        prev_cmd_q  <= m_command_queue;
        prev_data_q <= m_data_queue;
    end

    always_comb begin
        state_nxt      = state;
        cmd_idx_nxt    = cmd_idx;
        fb_addr_nxt    = fb_addr;
        init_done_nxt  = init_done;
        frame_done_nxt = 1'b0;
        dly_cnt_nxt    = dly_cnt;

        case (state)
            SEQ_PWR_WAIT: if (dly_cnt == PWR_LAST) state_nxt = SEQ_REQ;
            SEQ_REQ:      if (!mst_idle) state_nxt = SEQ_INIT;
            SEQ_INIT: begin
                if (mst_hung) begin
                    state_nxt = SEQ_FAULT;
                end else if (cmd_adv) begin
                    if (cmd_idx == INIT_LAST) begin
                        init_done_nxt = 1'b1;
                        fb_addr_nxt   = '0;
                        state_nxt     = SEQ_DATA;
                    end else begin
                        cmd_idx_nxt = cmd_idx + CMD_IDX_W'(1);
                    end
                end
            end
            SEQ_DATA: begin
                if (mst_hung) begin
                    state_nxt = SEQ_FAULT;
                end else if (data_adv) begin
                    if (fb_addr == FB_LAST) begin
                        fb_addr_nxt    = '0;
                        frame_done_nxt = 1'b1;
                    end else begin
                        fb_addr_nxt = fb_addr + FB_AW'(1);
                    end
                end
            end
            SEQ_FAULT:    if (dly_cnt == RETRY_LAST) state_nxt = SEQ_REQ;
            default:      state_nxt = SEQ_PWR_WAIT;
        endcase

        if (state_nxt == SEQ_FAULT) begin
            cmd_idx_nxt   = '0;
            fb_addr_nxt   = '0;
            init_done_nxt = 1'b0;
        end

        // Delay counter restarts on every state change and saturates at its limit
        if (state_nxt != state) begin
            dly_cnt_nxt = '0;
        end else if ((state == SEQ_PWR_WAIT && dly_cnt != PWR_LAST) ||
                     (state == SEQ_FAULT && dly_cnt != RETRY_LAST)) begin
            dly_cnt_nxt = dly_cnt + DLY_W'(1);
        end

        start_n_nxt       = (state_nxt != SEQ_REQ);
        fault_nxt         = (state_nxt == SEQ_FAULT);
        control_frame_nxt = (state_nxt == SEQ_DATA) ? CTRL_DATA : CTRL_CMD;
    end

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Scoreboard bench for oled_frame_sequencer: expected output snapshots are queued
// with each stimulus step and compared once the DUT has taken the clock edge.
module tb_oled_frame_sequencer;

    localparam int unsigned PWR   = 10;
    localparam int unsigned RETRY = 20;

    typedef struct {
        logic       start_n;
        logic [7:0] cf;
        logic       chk_cmd;
        logic [7:0] cmd;
        logic [9:0] addr;
        logic       init_done;
        logic       frame_done;
        logic       fault;
        logic       chk_db;
        logic [7:0] db;
    } snap_t;

    logic       CLK = 1'b0;
    logic       NRST;
    logic [3:0] m_state;
    logic [4:0] m_command_queue;
    logic [7:0] m_data_queue;
    logic       start_n;
    logic [6:0] slave_addr;
    logic       read_write;
    logic [7:0] control_frame;
    logic [7:0] cmd_byte;
    logic [7:0] data_byte;
    logic [9:0] fb_addr;
    logic [7:0] fb_data = 8'h00;
    logic       init_done;
    logic       frame_done;
    logic       fault;

    logic [7:0] rom_exp [0:30] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07,
        8'hAF
    };

    int    n_checks = 0;
    int    n_errors = 0;
    snap_t exp_q[$];

    oled_frame_sequencer #(
        .SLAVE_ADDR  (7'h3C),
        .PWR_DELAY   (PWR),
        .RETRY_DELAY (RETRY),
        .FB_BYTES    (1024),
        .INIT_LEN    (31)
    ) dut (
        .CLK             (CLK),
        .NRST            (NRST),
        .m_state         (m_state),
        .m_command_queue (m_command_queue),
        .m_data_queue    (m_data_queue),
        .start_n         (start_n),
        .slave_addr      (slave_addr),
        .read_write      (read_write),
        .control_frame   (control_frame),
        .cmd_byte        (cmd_byte),
        .data_byte       (data_byte),
        .fb_addr         (fb_addr),
        .fb_data         (fb_data),
        .init_done       (init_done),
        .frame_done      (frame_done),
        .fault           (fault)
    );

    always #5 CLK = ~CLK;

    // Framebuffer model: one-cycle read latency, contents = low address byte
    always @(posedge CLK) fb_data <= fb_addr[7:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic snap_t snap(input logic sn, input logic [7:0] cf, input logic chk_cmd,
                                   input logic [7:0] cmd, input logic [9:0] addr,
                                   input logic idone, input logic fdone, input logic flt);
        snap_t s;
        s.start_n    = sn;
        s.cf         = cf;
        s.chk_cmd    = chk_cmd;
        s.cmd        = cmd;
        s.addr       = addr;
        s.init_done  = idone;
        s.frame_done = fdone;
        s.fault      = flt;
        s.chk_db     = 1'b0;
        s.db         = 8'h00;
        return s;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        snap_t s;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            check("start_n", 32'(start_n), 32'(s.start_n));
            check("control_frame", 32'(control_frame), 32'(s.cf));
            if (s.chk_cmd) check("cmd_byte", 32'(cmd_byte), 32'(s.cmd));
            check("fb_addr", 32'(fb_addr), 32'(s.addr));
            check("init_done", 32'(init_done), 32'(s.init_done));
            check("frame_done", 32'(frame_done), 32'(s.frame_done));
            check("fault", 32'(fault), 32'(s.fault));
            if (s.chk_db) check("data_byte", 32'(data_byte), 32'(s.db));
        end
    endtask

    task automatic step(input snap_t s);
        exp_q.push_back(s);
        tick();
        drain();
    endtask

    // Walk the init list from index k0; the last advance must land in the data phase
    task automatic run_init(input int k0);
        for (int k = k0; k < 31; k++) begin
            m_command_queue = m_command_queue + 5'd1;
            if (k < 30) step(snap(1'b1, 8'h80, 1'b1, rom_exp[k + 1], 10'd0, 1'b0, 1'b0, 1'b0));
            else        step(snap(1'b1, 8'hC0, 1'b0, 8'h00, 10'd0, 1'b1, 1'b0, 1'b0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    n;
        snap_t s;
        NRST            = 1'b0;
        m_state         = 4'd0;
        m_command_queue = 5'd3;
        m_data_queue    = 8'd250;
        tick();
        tick();
        step(snap(1'b1, 8'h80, 1'b1, 8'hAE, 10'd0, 1'b0, 1'b0, 1'b0));
        check("slave_addr", 32'(slave_addr), 32'h3C);
        check("read_write", 32'(read_write), 32'h0);

        // Power-up wait: start request appears on the PWR-th edge
        NRST = 1'b1;
        for (int i = 1; i < int'(PWR); i++)
            step(snap(1'b1, 8'h80, 1'b1, 8'hAE, 10'd0, 1'b0, 1'b0, 1'b0));
        step(snap(1'b0, 8'h80, 1'b1, 8'hAE, 10'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++)
            step(snap(1'b0, 8'h80, 1'b1, 8'hAE, 10'd0, 1'b0, 1'b0, 1'b0));
        m_state = 4'd1;
        step(snap(1'b1, 8'h80, 1'b1, 8'hAE, 10'd0, 1'b0, 1'b0, 1'b0));

        m_state = 4'd4;
        run_init(0);

        // A stray command-pointer move in the data phase changes nothing
        m_state = 4'd5;
        m_command_queue = m_command_queue + 5'd1;
        step(snap(1'b1, 8'hC0, 1'b0, 8'h00, 10'd0, 1'b1, 1'b0, 1'b0));

        // Full frame plus wrap, crossing the 8-bit pointer wrap several times
        for (int k = 0; k < 1024; k++) begin
            m_data_queue = m_data_queue + 8'd1;
            s = snap(1'b1, 8'hC0, 1'b0, 8'h00, 10'((k + 1) % 1024), 1'b1, 1'(k == 1023), 1'b0);
            s.chk_db = 1'b1;
            s.db     = 8'(k);
            step(s);
        end
        s = snap(1'b1, 8'hC0, 1'b0, 8'h00, 10'd0, 1'b1, 1'b0, 1'b0);
        s.chk_db = 1'b1;
        s.db     = 8'h00;
        step(s);

        for (int k = 0; k < 500; k++) begin
            m_data_queue = m_data_queue + 8'd1;
            step(snap(1'b1, 8'hC0, 1'b0, 8'h00, 10'(k + 1), 1'b1, 1'b0, 1'b0));
        end

        // Master drops to IDLE for two cycles at fb_addr 500
        m_state = 4'd0;
        step(snap(1'b1, 8'hC0, 1'b0, 8'h00, 10'd500, 1'b1, 1'b0, 1'b0));
        step(snap(1'b1, 8'h80, 1'b1, 8'hAE, 10'd0, 1'b0, 1'b0, 1'b1));
        n = 0;
        while (start_n !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check("retry_cycles", 32'(n), 32'(RETRY));
        check("retry_fault", 32'(fault), 32'h0);
        check("retry_cmd_byte", 32'(cmd_byte), 32'hAE);

        m_state = 4'd1;
        step(snap(1'b1, 8'h80, 1'b1, 8'hAE, 10'd0, 1'b0, 1'b0, 1'b0));
        m_state = 4'd4;
        m_command_queue = m_command_queue + 5'd1;
        step(snap(1'b1, 8'h80, 1'b1, 8'hD5, 10'd0, 1'b0, 1'b0, 1'b0));
        m_command_queue = m_command_queue + 5'd1;
        step(snap(1'b1, 8'h80, 1'b1, 8'h80, 10'd0, 1'b0, 1'b0, 1'b0));

        // Single-cycle IDLE glitch mid-init is not a fault
        m_state = 4'd0;
        step(snap(1'b1, 8'h80, 1'b1, 8'h80, 10'd0, 1'b0, 1'b0, 1'b0));
        m_state = 4'd4;
        step(snap(1'b1, 8'h80, 1'b1, 8'h80, 10'd0, 1'b0, 1'b0, 1'b0));
        run_init(2);

        m_state = 4'd5;
        for (int k = 0; k < 10; k++) begin
            m_data_queue = m_data_queue + 8'd1;
            step(snap(1'b1, 8'hC0, 1'b0, 8'h00, 10'(k + 1), 1'b1, 1'b0, 1'b0));
        end

        // Synchronous reset mid-data returns everything to its reset value
        NRST = 1'b0;
        step(snap(1'b1, 8'h80, 1'b1, 8'hAE, 10'd0, 1'b0, 1'b0, 1'b0));
        NRST = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/oled_frame_sequencer.md
Name: oled_frame_sequencer

Overview:
- Upstream byte source for the I2C master that drives an SSD1306 128x64 OLED.
- After power-up it requests a transaction, then serves the SSD1306 init command list one byte at a time.
- It then streams the 1024-byte framebuffer continuously, wrapping every frame.
- It paces itself purely on the master's state and queue-pointer outputs. A master drop-back to IDLE (NACK path) triggers a delayed full restart.

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit OLED address driven to master.
- PWR_DELAY, 100000, CLK cycles waited after reset before first start request.
- RETRY_DELAY, 50000, CLK cycles waited in FAULT before restart.
- FB_BYTES, 1024, framebuffer bytes per frame (128x64/8).
- INIT_LEN, 31, number of init command bytes.

Ports:
- CLK  in  1  system clock
- NRST  in  1  synchronous active-low reset
- m_state  in  4  master FSM state (0=IDLE, 1=START, 3=WRITE_CONTROL, 4=WRITE_COMMAND, 5=WRITE_DATA, 7=ACK, 8=STOP)
- m_command_queue  in  5  master command-byte counter, increments once per command byte shifted
- m_data_queue  in  8  master data-byte counter, increments once per data byte shifted
- start_n  out  1  active-low transaction request to master
- slave_addr  out  7  constant SLAVE_ADDR
- read_write  out  1  constant 0 (write)
- control_frame  out  8  0x80 in command phase, 0xC0 in data phase
- cmd_byte  out  8  current init command (master reg_addr input)
- data_byte  out  8  current pixel byte (master data_write input), equals fb_data
- fb_addr  out  10  framebuffer read address
- fb_data  in  8  framebuffer read data, valid 1 CLK after fb_addr
- init_done  out  1  level, high once all INIT_LEN commands have been consumed
- frame_done  out  1  1-cycle pulse when the last byte of a frame is consumed
- fault  out  1  level, high while in FAULT

Behaviour:
- Reset (NRST=0 at posedge CLK, from any state):
  - state=PWR_WAIT, delay counter=0, start_n=1, control_frame=0x80.
  - cmd_idx=0, so cmd_byte=ROM[0]=0xAE; fb_addr=0.
  - init_done=0, frame_done=0, fault=0.
  - Previous-pointer registers load the current m_command_queue and m_data_queue values.
- Edge detect:
  - cmd_adv = (m_command_queue != prev); data_adv = (m_data_queue != prev).
  - prev registers update every cycle, so pointer wrap (31->0, 255->0) counts as one advance.
- PWR_WAIT: count to PWR_DELAY-1, then go to REQ.
- REQ:
  - start_n=0, held until m_state != 0, then start_n=1 and go to INIT.
  - start_n stays low while m_state stays 0.
- INIT:
  - control_frame=0x80; cmd_byte=ROM[cmd_idx].
  - On cmd_adv: if cmd_idx==INIT_LEN-1, set init_done=1, fb_addr=0, go to DATA; else cmd_idx+1.
  - The switch happens during the master's ACK, so its next control frame is 0xC0.
- DATA:
  - control_frame=0xC0; data_byte=fb_data.
  - On data_adv: fb_addr+1. At FB_BYTES-1, wrap to 0 and pulse frame_done.
  - Refresh is continuous; the master never needs a re-request.
- Fault detect: in INIT or DATA, m_state==0 for 2 consecutive cycles means the master completed STOP after a NACK. Go to FAULT.
- FAULT:
  - fault=1; reset cmd_idx, fb_addr, init_done.
  - Count to RETRY_DELAY-1, then go to REQ with fault=0.
- Simultaneous cmd_adv and data_adv: cannot legally occur. Priority goes to the current phase's pointer and the other pointer is ignored.
- cmd_adv in DATA or data_adv in INIT: ignored, prev still updated.
- Counters: 17-bit delay counter saturating at its compare value. cmd_idx is 5 bits, fb_addr is 10 bits.

Decomposition:
- Shared package oled_pkg holds:
  - master state encodings (IDLE..STOP);
  - control bytes CTRL_CMD=0x80 and CTRL_DATA=0xC0;
  - sequencer state enum (PWR_WAIT, REQ, INIT, DATA, FAULT);
  - OLED geometry constants.
- Sub-module oled_init_rom is a combinational 5-bit index to 8-bit byte lookup. Contents, in order: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 21 00 7F 22 00 07 AF. Unused indices return 0xE3 (NOP).

Test Plan:
- Reset, PWR_DELAY=10: start_n stays 1 for 10 cycles, then goes 0. Hold m_state=0 for 5 cycles: start_n stays 0. Set m_state=1: start_n=1 the next cycle.
- In INIT, step m_command_queue 0..30: cmd_byte follows the ROM list AE,D5,80,... and control_frame=0x80. After the 31st step: init_done=1, control_frame=0xC0, fb_addr=0.
- In DATA with fb_data=fb_addr[7:0] model, step m_data_queue 1024 times: fb_addr 0..1023 then 0. frame_done pulses exactly once, in the cycle after the 1024th step. The 8-bit pointer wrap at 255->0 advances correctly.
- Fault: mid-DATA at fb_addr=500, drive m_state=0 for 2 cycles: fault=1, init_done=0. After RETRY_DELAY: start_n=0 and cmd_byte=0xAE.
- Glitch: m_state=0 for a single cycle mid-INIT gives no fault. Assert NRST mid-DATA: all outputs return to reset values next cycle.
